// File: rtl/mag_latch_bank.sv
// mag_latch_bank: a bank of N_CH independent magnet latch channels.
// Each channel runs its own OFF -> ON -> COOL -> OFF state machine:
// set/reset requests latch the magnet on or release it, and every
// release is followed by a forced-off cooling window of COOLDOWN cycles.
// Optional hold-limit auto-release is compiled in with `define MAG_TIMEOUT_EN;
// without it, ON persists until an effective reset and timeout is tied to 0.
// Request handling: set/reset are level requests sampled on every rising
// edge (no handshake); the outputs are registered state decodes.
module mag_latch_bank #(
   parameter int N_CH     = 4,
   parameter int HOLD_MAX = 1000,
   parameter int COOLDOWN = 8,
   parameter int RST_PRIO = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] set,
   input  logic [N_CH-1:0] reset,
   output logic [N_CH-1:0] mag_on,
   output logic [N_CH-1:0] cooling,
   output logic [N_CH-1:0] timeout
);

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_COOL = 2'd2;

   // Last cooling cycle index; unused when COOLDOWN is 0 (release goes straight to OFF).
   localparam logic [7:0] COOL_LAST = 8'(COOLDOWN - 1);

`ifdef MAG_TIMEOUT_EN
   // Hold count at which the channel has been ON for HOLD_MAX cycles.
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
`endif

   logic [N_CH-1:0] eff_set;
   logic [N_CH-1:0] eff_rst;

   // Resolve simultaneous set and reset according to RST_PRIO.
   always_comb begin
      eff_set = '0;
      eff_rst = '0;
      if (RST_PRIO != 0) begin
         eff_set = set & ~reset;
         eff_rst = reset;
      end else begin
         eff_set = set;
         eff_rst = reset & ~set;
      end
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      logic [1:0] state_q;
      logic [7:0] cool_cnt_q;
      logic       hold_expire;

`ifdef MAG_TIMEOUT_EN
      logic [15:0] hold_cnt_q;
      logic        timeout_q;

      assign hold_expire = (state_q == ST_ON) && (hold_cnt_q == HOLD_LAST);

      // Hold counter: cleared on entry to ON, counts ON cycles, saturates at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            hold_cnt_q <= '0;
         end else if (state_q == ST_OFF && eff_set[ch]) begin
            hold_cnt_q <= '0;
         end else if (state_q == ST_ON && hold_cnt_q != 16'hFFFF) begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
         end
      end

      // Sticky timeout: raised only by a pure auto-release, cleared by the next accepted set.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            timeout_q <= 1'b0;
         end else if (state_q == ST_OFF && eff_set[ch]) begin
            timeout_q <= 1'b0;
         end else if (hold_expire && !eff_rst[ch]) begin
            timeout_q <= 1'b1;
         end
      end

      assign timeout[ch] = timeout_q;
`else
      assign hold_expire = 1'b0;
      assign timeout[ch] = 1'b0;
`endif

      // Channel FSM: latch on set, release on reset or hold expiry, then cool down.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q    <= ST_OFF;
            cool_cnt_q <= '0;
         end else begin
            case (state_q)
               ST_OFF: begin
                  if (eff_set[ch]) begin
                     state_q <= ST_ON;
                  end
               end
               ST_ON: begin
                  if (eff_rst[ch] || hold_expire) begin
                     cool_cnt_q <= '0;
                     if (COOLDOWN == 0) begin
                        state_q <= ST_OFF;
                     end else begin
                        state_q <= ST_COOL;
                     end
                  end
               end
               ST_COOL: begin
                  if (cool_cnt_q == COOL_LAST) begin
                     state_q    <= ST_OFF;
                     cool_cnt_q <= '0;
                  end else begin
                     cool_cnt_q <= cool_cnt_q + 8'd1;
                  end
               end
               default: begin
                  state_q    <= ST_OFF;
                  cool_cnt_q <= '0;
               end
            endcase
         end
      end

      assign mag_on[ch]  = (state_q == ST_ON);
      assign cooling[ch] = (state_q == ST_COOL);
   end

endmodule

// File: tb/tb_mag_latch_bank.sv
// Testbench for mag_latch_bank. Three instances run side by side on the
// same stimulus: reset-priority (index 0), set-priority (index 1) and a
// zero-cooldown variant (index 2). A cycle-level reference model of the
// channel rules predicts every output; table vectors and short hand-written
// sequences add explicit expectations for the main instance.
module tb_mag_latch_bank;

   localparam int HOLD = 5;
`ifdef MAG_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] set_i;
   logic [3:0] reset_i;
   logic [3:0] mag_on_w  [3];
   logic [3:0] cooling_w [3];
   logic [3:0] timeout_w [3];

   int n_tests;
   int n_fail;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t run did not finish", $time);
      $fatal(1, "watchdog");
   end

   mag_latch_bank #(.N_CH(4), .HOLD_MAX(HOLD), .COOLDOWN(3), .RST_PRIO(1)) dut (
      .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i),
      .mag_on(mag_on_w[0]), .cooling(cooling_w[0]), .timeout(timeout_w[0])
   );

   mag_latch_bank #(.N_CH(4), .HOLD_MAX(HOLD), .COOLDOWN(3), .RST_PRIO(0)) dut_sp (
      .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i),
      .mag_on(mag_on_w[1]), .cooling(cooling_w[1]), .timeout(timeout_w[1])
   );

   mag_latch_bank #(.N_CH(4), .HOLD_MAX(HOLD), .COOLDOWN(0), .RST_PRIO(1)) dut_c0 (
      .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i),
      .mag_on(mag_on_w[2]), .cooling(cooling_w[2]), .timeout(timeout_w[2])
   );

   // ---------------- reference model ----------------
   int prio_p [3] = '{1, 0, 1};
   int cool_p [3] = '{3, 3, 0};
   int m_on   [3][4];
   int m_cool [3][4];   // remaining forced-off cycles
   int m_held [3][4];   // cycles spent ON since latching
   int m_to   [3][4];

   logic [11:0] exp_q[$];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 4; c++) begin
            m_on[i][c] = 0; m_cool[i][c] = 0; m_held[i][c] = 0; m_to[i][c] = 0;
         end
      end
      exp_q.delete();
   endtask

   task automatic model_step(input logic [3:0] s, input logic [3:0] r);
      bit es, er, expire;
      logic [3:0] e_on, e_cool, e_to;
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 4; c++) begin
            es = (prio_p[i] != 0) ? (s[c] && !r[c]) : s[c];
            er = (prio_p[i] != 0) ? r[c] : (r[c] && !s[c]);
            if (m_cool[i][c] > 0) begin
               m_cool[i][c] = m_cool[i][c] - 1;
            end else if (m_on[i][c] != 0) begin
               m_held[i][c] = m_held[i][c] + 1;
               expire = TO_EN && (m_held[i][c] >= HOLD);
               if (er || expire) begin
                  m_on[i][c]   = 0;
                  m_cool[i][c] = cool_p[i];
                  if (!er) m_to[i][c] = 1;
               end
            end else if (es) begin
               m_on[i][c]   = 1;
               m_held[i][c] = 0;
               m_to[i][c]   = 0;
            end
         end
         for (int c = 0; c < 4; c++) begin
            e_on[c]   = (m_on[i][c] != 0);
            e_cool[c] = (m_cool[i][c] > 0);
            e_to[c]   = (m_to[i][c] != 0);
         end
         exp_q.push_back({e_on, e_cool, e_to});
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_model();
      logic [11:0] got, exp;
      for (int i = 0; i < 3; i++) begin
         got = {mag_on_w[i], cooling_w[i], timeout_w[i]};
         exp = exp_q.pop_front();
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL model inst%0d t=%0t got on/cool/to=%b/%b/%b exp=%b/%b/%b",
                     i, $time, got[11:8], got[7:4], got[3:0], exp[11:8], exp[7:4], exp[3:0]);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input logic [3:0] s, input logic [3:0] r);
      set_i   = s;
      reset_i = r;
      @(posedge clk);
      model_step(s, r);
      #1;
      check_model();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(4'b0000, 4'b0000);
   endtask

   // Pull rst_n low between edges and check that outputs clear without a clock.
   task automatic async_reset(input string name);
      #3;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk({name, "_on"},   32'(mag_on_w[i]),  32'h0);
         chk({name, "_cool"}, 32'(cooling_w[i]), 32'h0);
         chk({name, "_to"},   32'(timeout_w[i]), 32'h0);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] s;
      logic [3:0] r;
      logic [3:0] on;
      logic [3:0] cool;
      logic [3:0] to;
      logic [3:0] on_sp;
   } vec_t;

   vec_t tbl [14];

   // ---------------- test sequence ----------------
   initial begin
      int on_cnt;
      logic [3:0] rs, rr;

      n_tests = 0;
      n_fail  = 0;
      //          set      reset    on       cool     to       on(set-prio)
      tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
      tbl[1]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
      tbl[2]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
      tbl[3]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[7]  = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
      tbl[8]  = '{4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[9]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
      tbl[10] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
      tbl[11] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
      tbl[12] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
      tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      rst_n   = 1'b0;
      set_i   = 4'b0000;
      reset_i = 4'b0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_on",   32'(mag_on_w[i]),  32'h0);
         chk("rst_cool", 32'(cooling_w[i]), 32'h0);
         chk("rst_to",   32'(timeout_w[i]), 32'h0);
      end
      rst_n = 1'b1;

      // Table: pulse/latch/release, simultaneous requests, set during cooling.
      for (int v = 0; v < 14; v++) begin
         cycle(tbl[v].s, tbl[v].r);
         chk($sformatf("tbl%0d_on", v),    32'(mag_on_w[0]),  32'(tbl[v].on));
         chk($sformatf("tbl%0d_cool", v),  32'(cooling_w[0]), 32'(tbl[v].cool));
         chk($sformatf("tbl%0d_to", v),    32'(timeout_w[0]), 32'(tbl[v].to));
         chk($sformatf("tbl%0d_on_sp", v), 32'(mag_on_w[1]),  32'(tbl[v].on_sp));
      end
      cycle(4'b0000, 4'b1111);
      chk("c0_direct_off_on",   32'(mag_on_w[2]),  32'h0);
      chk("c0_direct_off_cool", 32'(cooling_w[2]), 32'h0);
      idle(4);

      // Hold set[1]: limited to HOLD cycles when auto-release is built in.
      on_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(4'b0010, 4'b0000);
         if (mag_on_w[0][1]) on_cnt++;
      end
      chk("hold_len", 32'(on_cnt), TO_EN ? 32'd5 : 32'd8);
      cycle(4'b0000, 4'b0000);
      chk("hold_to_sticky", 32'(timeout_w[0][1]), 32'(TO_EN));
      cycle(4'b0010, 4'b0000);
      chk("reset_after_to_on", 32'(mag_on_w[0][1]),  32'h1);
      chk("reset_after_to_to", 32'(timeout_w[0][1]), 32'h0);
      cycle(4'b0000, 4'b0010);
      idle(4);

      // Hold expiry coinciding with an effective reset: release without timeout.
      cycle(4'b1000, 4'b0000);
      idle(4);
      cycle(4'b0000, 4'b1000);
      chk("expire_rst_on",   32'(mag_on_w[0][3]),  32'h0);
      chk("expire_rst_cool", 32'(cooling_w[0][3]), 32'h1);
      chk("expire_rst_to",   32'(timeout_w[0][3]), 32'h0);
      idle(4);

      // Long hold on set[3].
      on_cnt = 0;
      for (int k = 0; k < 100; k++) begin
         cycle(4'b1000, 4'b0000);
         if (mag_on_w[0][3]) on_cnt++;
      end
`ifndef MAG_TIMEOUT_EN
      chk("long_hold_on",  32'(on_cnt), 32'd100);
      chk("long_hold_to",  32'(timeout_w[0]), 32'h0);
`else
      chk("long_hold_to",  32'(timeout_w[0][3]), 32'h1);
`endif
      cycle(4'b0000, 4'b1000);
      idle(4);

      // Randomized traffic against the model, with one async reset mid-run.
      for (int k = 0; k < 400; k++) begin
         rs = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         rr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         cycle(rs, rr);
         if (k == 200) async_reset("rand_rst");
      end

      // Reset mid-ON, then the first sampled set after release is honoured.
      cycle(4'b0000, 4'b1111);
      idle(4);
      cycle(4'b1111, 4'b0000);
      chk("pre_rst_on", 32'(mag_on_w[0]), 32'hF);
      async_reset("mid_on_rst");
      cycle(4'b0100, 4'b0000);
      chk("first_set_after_rst", 32'(mag_on_w[0]), 32'h4);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
